seq_pc_ctrl: RTL and testbench

- Program-counter sequencer and status controller for the SEQ Y86-64 core.
- Owns the architectural PC that drives fetch_seq.p_ctr and selects the next PC from fetch, execute and memory results.
- Tracks the processor status code, stalls on data-memory latency, and gates state commits (register-file, data-memory and CC writes).
- Provides cycle and instruction counters for benches and debug.

---
 rtl/y86_pkg.sv | 34 +++
 rtl/seq_pc_ctrl_if.sv | 32 +++
 rtl/seq_new_pc.sv | 24 ++
 rtl/seq_pc_ctrl.sv | 76 +++++++
 tb/tb_seq_pc_ctrl.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: icodes, status codes and the SEQ sequencer state.
package y86_pkg;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam logic [2:0] S_AOK = 3'd1;
   localparam logic [2:0] S_HLT = 3'd2;
   localparam logic [2:0] S_ADR = 3'd3;
   localparam logic [2:0] S_INS = 3'd4;

   typedef enum logic [1:0] {IDLE, RUN, STOP} seq_state_t;

   // Status for this cycle's fault sources, highest priority first; S_AOK means no fault.
   function automatic logic [2:0] fault_stat(input logic bad_mem, input logic in_error,
                                             input logic dmem_fault, input logic flag_halt);
      if (bad_mem)         return S_ADR;
      else if (in_error)   return S_INS;
      else if (dmem_fault) return S_ADR;
      else if (flag_halt)  return S_HLT;
      else                 return S_AOK;
   endfunction

endpackage

// File: rtl/seq_pc_ctrl_if.sv
// Bus between the SEQ datapath (master) and the PC sequencer (slave).
interface seq_pc_ctrl_if #(parameter int CNT_W = 32);
   logic             start;
   logic [3:0]       in_code;
   logic             flag_halt;
   logic             bad_mem;
   logic             in_error;
   logic [63:0]      val_c;
   logic [63:0]      val_p;
   logic [63:0]      val_m;
   logic             cnd;
   logic             mem_ready;
   logic             dmem_error;
   logic [63:0]      p_ctr;
   logic [2:0]       stat;
   logic             commit;
   logic             running;
   logic [CNT_W-1:0] cycle_count;
   logic [CNT_W-1:0] instr_count;

   modport master (
      output start, in_code, flag_halt, bad_mem, in_error, val_c, val_p, val_m,
             cnd, mem_ready, dmem_error,
      input  p_ctr, stat, commit, running, cycle_count, instr_count
   );

   modport slave (
      input  start, in_code, flag_halt, bad_mem, in_error, val_c, val_p, val_m,
             cnd, mem_ready, dmem_error,
      output p_ctr, stat, commit, running, cycle_count, instr_count
   );
endinterface

// File: rtl/seq_new_pc.sv
// Combinational next-PC select; shared with the PIPE predict/correct logic.
module seq_new_pc
   import y86_pkg::*;
(
   input  logic [3:0]  in_code,
   input  logic        cnd,
   input  logic [63:0] val_c,
   input  logic [63:0] val_p,
   input  logic [63:0] val_m,
   output logic [63:0] new_pc
);

   // call and taken jumps go to the constant, ret to the popped address.
   always_comb begin
      new_pc = val_p;
      case (in_code)
         I_CALL:  new_pc = val_c;
         I_JXX:   new_pc = cnd ? val_c : val_p;
         I_RET:   new_pc = val_m;
         default: new_pc = val_p;
      endcase
   end

endmodule

// File: rtl/seq_pc_ctrl.sv
// SEQ PC sequencer: owns the PC, latches the status code, gates commits and counts.
//
// state | meaning
// IDLE  | after reset, outputs held until start
// RUN   | one instruction evaluated per completing cycle
// STOP  | terminal after a fault or halt; only reset leaves
module seq_pc_ctrl
   import y86_pkg::*;
#(
   parameter logic [63:0] START_PC = 64'd0,
   parameter int          CNT_W    = 32
)(
   input logic          clock,
   input logic          reset_n,
   seq_pc_ctrl_if.slave bus
);

   seq_state_t       state;
   logic [63:0]      p_ctr_q;
   logic [2:0]       stat_q;
   logic [CNT_W-1:0] cycle_q;
   logic [CNT_W-1:0] instr_q;
   logic [63:0]      new_pc;
   logic [2:0]       cur_fault;

   seq_new_pc u_new_pc (
      .in_code (bus.in_code),
      .cnd     (bus.cnd),
      .val_c   (bus.val_c),
      .val_p   (bus.val_p),
      .val_m   (bus.val_m),
      .new_pc  (new_pc)
   );

   // A data-memory error only counts once the access has actually completed.
   always_comb begin
      cur_fault = fault_stat(bus.bad_mem, bus.in_error,
                             bus.dmem_error & bus.mem_ready, bus.flag_halt);
   end

   // Sequencer FSM: PC, status latch and counters advance together.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         p_ctr_q <= START_PC;
         stat_q  <= S_AOK;
         cycle_q <= '0;
         instr_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) state <= RUN;
            end
            RUN: begin
               cycle_q <= cycle_q + CNT_W'(1);
               if (cur_fault != S_AOK) begin
                  stat_q <= cur_fault;
                  state  <= STOP;
               end else if (bus.mem_ready) begin
                  p_ctr_q <= new_pc;
                  instr_q <= instr_q + CNT_W'(1);
               end
            end
            default: state <= STOP;
         endcase
      end
   end

   assign bus.p_ctr       = p_ctr_q;
   assign bus.stat        = stat_q;
   assign bus.running     = (state == RUN);
   assign bus.commit      = (state == RUN) && (cur_fault == S_AOK) && bus.mem_ready;
   assign bus.cycle_count = cycle_q;
   assign bus.instr_count = instr_q;

endmodule

// File: tb/tb_seq_pc_ctrl.sv
// Scoreboard bench for seq_pc_ctrl: directed program-flow cases plus random runs.
module tb_seq_pc_ctrl;

   localparam logic [63:0] START_PC = 64'd0;

   typedef struct packed {
      logic        start;
      logic [3:0]  in_code;
      logic        flag_halt;
      logic        bad_mem;
      logic        in_error;
      logic [63:0] val_c;
      logic [63:0] val_p;
      logic [63:0] val_m;
      logic        cnd;
      logic        mem_ready;
      logic        dmem_error;
   } in_t;

   typedef struct packed {
      logic [63:0] pc;
      logic [2:0]  stat;
      logic        commit;
      logic        running;
      logic [31:0] cyc;
      logic [31:0] ins;
   } exp_t;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   int   errors = 0;
   int   checks = 0;
   exp_t sbq[$];
   in_t  cur;

   // Reference model: plain bookkeeping of the architectural view.
   bit          m_started, m_stopped;
   logic [63:0] m_pc;
   logic [2:0]  m_stat;
   logic [31:0] m_cyc, m_ins;

   seq_pc_ctrl_if #(.CNT_W(32)) bus ();

   seq_pc_ctrl #(.START_PC(START_PC), .CNT_W(32)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   assign bus.start      = cur.start;
   assign bus.in_code    = cur.in_code;
   assign bus.flag_halt  = cur.flag_halt;
   assign bus.bad_mem    = cur.bad_mem;
   assign bus.in_error   = cur.in_error;
   assign bus.val_c      = cur.val_c;
   assign bus.val_p      = cur.val_p;
   assign bus.val_m      = cur.val_m;
   assign bus.cnd        = cur.cnd;
   assign bus.mem_ready  = cur.mem_ready;
   assign bus.dmem_error = cur.dmem_error;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [2:0] m_fault(input in_t v);
      if (v.bad_mem) return 3'd3;
      if (v.in_error) return 3'd4;
      if (v.dmem_error && v.mem_ready) return 3'd3;
      if (v.flag_halt) return 3'd2;
      return 3'd1;
   endfunction

   function automatic logic [63:0] m_next_pc(input in_t v);
      if (v.in_code == 4'd8) return v.val_c;
      if (v.in_code == 4'd7 && v.cnd) return v.val_c;
      if (v.in_code == 4'd9) return v.val_m;
      return v.val_p;
   endfunction

   task automatic model_reset();
      m_started = 0; m_stopped = 0;
      m_pc = START_PC; m_stat = 3'd1; m_cyc = 0; m_ins = 0;
   endtask

   // Apply one clock edge worth of behaviour for inputs v.
   task automatic model_edge(input in_t v);
      if (!m_started) begin
         if (v.start) m_started = 1;
      end else if (!m_stopped) begin
         m_cyc = m_cyc + 1;
         if (m_fault(v) != 3'd1) begin
            m_stopped = 1;
            m_stat = m_fault(v);
         end else if (v.mem_ready) begin
            m_pc = m_next_pc(v);
            m_ins = m_ins + 1;
         end
      end
   endtask

   // One cycle: retire the edge just taken, drive new inputs, queue the expected view.
   task automatic drive(input in_t v);
      exp_t e;
      @(posedge clock);
      #1;
      model_edge(cur);
      cur = v;
      e.pc = m_pc;
      e.stat = m_stat;
      e.running = m_started && !m_stopped;
      e.commit = e.running && (m_fault(v) == 3'd1) && v.mem_ready;
      e.cyc = m_cyc;
      e.ins = m_ins;
      sbq.push_back(e);
   endtask

   function automatic in_t idle_in();
      in_t v;
      v = '0;
      v.in_code = 4'd1;
      v.mem_ready = 1'b1;
      return v;
   endfunction

   function automatic in_t instr(input logic [3:0] ic, input logic [63:0] vc,
                                 input logic [63:0] vp, input logic [63:0] vm, input logic c);
      in_t v;
      v = idle_in();
      v.in_code = ic; v.val_c = vc; v.val_p = vp; v.val_m = vm; v.cnd = c;
      return v;
   endfunction

   // Asynchronous reset between edges; outputs must clear without a clock.
   task automatic do_reset();
      @(negedge clock);
      #2;
      reset_n = 1'b0;
      cur = idle_in();
      #1;
      check("rst_p_ctr", bus.p_ctr, START_PC);
      check("rst_stat", 64'(bus.stat), 64'd1);
      check("rst_commit", 64'(bus.commit), 64'd0);
      check("rst_running", 64'(bus.running), 64'd0);
      check("rst_cycle", 64'(bus.cycle_count), 64'd0);
      check("rst_instr", 64'(bus.instr_count), 64'd0);
      model_reset();
      #1;
      reset_n = 1'b1;
   endtask

   // Monitor: compare DUT outputs with the oldest queued expectation.
   always @(negedge clock) begin
      if (sbq.size() > 0) begin
         exp_t e;
         e = sbq.pop_front();
         check("p_ctr", bus.p_ctr, e.pc);
         check("stat", 64'(bus.stat), 64'(e.stat));
         check("commit", 64'(bus.commit), 64'(e.commit));
         check("running", 64'(bus.running), 64'(e.running));
         check("cycle_count", 64'(bus.cycle_count), 64'(e.cyc));
         check("instr_count", 64'(bus.instr_count), 64'(e.ins));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      in_t v;
      cur = idle_in();
      model_reset();
      do_reset();

      // Idle cycles without start, then start and program flow.
      drive(idle_in());
      drive(idle_in());
      v = idle_in(); v.start = 1; drive(v);
      drive(instr(4'd3, 64'h0, 64'd10, 64'h0, 1'b0));            // irmovq
      drive(instr(4'd7, 64'h40, 64'd9, 64'h0, 1'b1));            // jXX taken
      drive(instr(4'd7, 64'h40, 64'd9, 64'h0, 1'b0));            // jXX not taken
      drive(instr(4'd8, 64'h80, 64'd9, 64'h0, 1'b0));            // call
      drive(instr(4'd9, 64'h0, 64'h81, 64'h1B, 1'b0));           // ret
      v = instr(4'd4, 64'h0, 64'h25, 64'h0, 1'b0); v.mem_ready = 0;
      drive(v); drive(v); drive(v);                              // rmmovq stall x3
      v.mem_ready = 1; drive(v);
      v = instr(4'd8, 64'h20, 64'h2E, 64'h0, 1'b0); v.start = 1; // start in RUN ignored
      drive(v);
      v = instr(4'd0, 64'h0, 64'h21, 64'h0, 1'b0); v.flag_halt = 1;
      drive(v);
      v = idle_in(); v.start = 1; drive(v);                      // start in STOP ignored
      drive(idle_in());
      drive(idle_in());

      // bad_mem with in_error -> ADR.
      do_reset();
      v = idle_in(); v.start = 1; drive(v);
      v = instr(4'd2, 64'h0, 64'h2, 64'h0, 1'b0); v.bad_mem = 1; v.in_error = 1; drive(v);
      drive(idle_in()); drive(idle_in());

      // in_error alone -> INS.
      do_reset();
      v = idle_in(); v.start = 1; drive(v);
      drive(instr(4'd1, 64'h0, 64'h1, 64'h0, 1'b0));
      v = instr(4'd1, 64'h0, 64'h2, 64'h0, 1'b0); v.in_error = 1; drive(v);
      drive(idle_in()); drive(idle_in());

      // dmem_error: ignored while stalled, faults once the access completes.
      do_reset();
      v = idle_in(); v.start = 1; drive(v);
      v = instr(4'd5, 64'h0, 64'hA, 64'h0, 1'b0); v.dmem_error = 1; v.mem_ready = 0;
      drive(v);
      v.mem_ready = 1; drive(v);
      drive(idle_in()); drive(idle_in());

      // Random runs, each ended by an asynchronous reset possibly mid-RUN.
      for (int ep = 0; ep < 25; ep++) begin
         do_reset();
         for (int c = 0; c < 40 + ep; c++) begin
            v.start      = ($urandom_range(0, 5) == 0);
            v.in_code    = 4'($urandom_range(0, 11));
            v.flag_halt  = ($urandom_range(0, 60) == 0);
            v.bad_mem    = ($urandom_range(0, 80) == 0);
            v.in_error   = ($urandom_range(0, 80) == 0);
            v.val_c      = {$urandom, $urandom};
            v.val_p      = {$urandom, $urandom};
            v.val_m      = {$urandom, $urandom};
            v.cnd        = 1'($urandom_range(0, 1));
            v.mem_ready  = ($urandom_range(0, 3) != 0);
            v.dmem_error = ($urandom_range(0, 60) == 0);
            drive(v);
         end
      end

      @(negedge clock);
      #1;
      check("queue_drained", 64'(sbq.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
